// File: rtl/jg_bus_ctrl.sv
// Z80 bus controller for the Mr. Jong / Senhor boards: address decode, per-region
// wait states, one-shot I/O write strobes, control latch and unmapped-access log.
module jg_bus_ctrl #(
  parameter int NUM_SN   = 2,
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0,
  parameter int VID_WAIT = 1,
  parameter int IO_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cpu_ab,
  input  logic              cpu_io,
  input  logic              cpu_m1,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_dout,
  output logic              rom_cs,
  output logic              ram1_cs,
  output logic              ram2_cs,
  output logic              vram_cs,
  output logic              cram_cs,
  output logic              p1_cs,
  output logic              p2_cs,
  output logic              dsw_cs,
  output logic [NUM_SN-1:0] sn_wr,
  output logic [7:0]        ctrl_q,
  output logic              flip,
  output logic              cpu_wait_n,
  output logic [7:0]        unmap_cnt,
  output logic [15:0]       unmap_addr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_reg;
  logic [3:0]        wcnt_reg;
  logic [7:0]        ctrl_reg;
  logic              wait_n_reg;
  logic [NUM_SN-1:0] sn_wr_reg;
  logic [7:0]        unmap_cnt_reg;
  logic [15:0]       unmap_addr_reg;

  logic              req, mem_acc, io_acc;
  logic [7:0]        port;
  logic              rom_hit, ram1_hit, ram2_hit, vid_hit, mem_mapped;
  logic              io_rd_mapped, io_wr_mapped, io_mapped, unmapped;
  logic [NUM_SN-1:0] sn_hit;
  logic [3:0]        wait_val;

  assign req     = cpu_rd | cpu_wr;
  assign mem_acc = ~cpu_io;
  assign io_acc  = cpu_io & ~cpu_m1;
  assign port    = cpu_ab[7:0];

  assign rom_hit    = ~cpu_ab[15];
  assign ram1_hit   = (cpu_ab[15:11] == 5'b10000);
  assign ram2_hit   = (cpu_ab[15:11] == 5'b10100);
  assign vid_hit    = (cpu_ab[15:11] == 5'b11100);
  assign mem_mapped = rom_hit | ram1_hit | ram2_hit | vid_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SN; gi++) begin : g_sn
      assign sn_hit[gi] = io_acc & cpu_wr & (port == 8'(gi + 1));
    end
  endgenerate

  // Port 3 decodes in both directions but drives nothing.
  assign io_rd_mapped = cpu_rd & (port <= 8'd3);
  assign io_wr_mapped = cpu_wr & ((port == 8'd0) | (port == 8'd3) | (|sn_hit));
  assign io_mapped    = cpu_wr ? io_wr_mapped : io_rd_mapped;
  assign unmapped     = req & ((mem_acc & ~mem_mapped) | (io_acc & ~io_mapped));

  // Unmapped accesses and interrupt acknowledge complete with no wait states.
  always_comb begin
    wait_val = 4'd0;
    if (mem_acc) begin
      if (rom_hit)                    wait_val = 4'(ROM_WAIT);
      else if (ram1_hit | ram2_hit)   wait_val = 4'(RAM_WAIT);
      else if (vid_hit)               wait_val = 4'(VID_WAIT);
    end else if (io_acc && io_mapped) begin
      wait_val = 4'(IO_WAIT);
    end
  end

  assign rom_cs  = req & mem_acc & rom_hit;
  assign ram1_cs = req & mem_acc & ram1_hit;
  assign ram2_cs = req & mem_acc & ram2_hit;
  assign vram_cs = req & mem_acc & vid_hit & ~cpu_ab[10];
  assign cram_cs = req & mem_acc & vid_hit & cpu_ab[10];
  assign p2_cs   = io_acc & cpu_rd & (port == 8'd0);
  assign p1_cs   = io_acc & cpu_rd & (port == 8'd1);
  assign dsw_cs  = io_acc & cpu_rd & (port == 8'd2);

  // sn_wr is loaded on the edge entering ACT, so it is high for exactly the ACT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      wcnt_reg       <= 4'd0;
      ctrl_reg       <= 8'd0;
      wait_n_reg     <= 1'b1;
      sn_wr_reg      <= '0;
      unmap_cnt_reg  <= 8'd0;
      unmap_addr_reg <= 16'd0;
    end else begin
      sn_wr_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            wcnt_reg <= wait_val;
            if (wait_val != 4'd0) begin
              state_reg  <= S_WAIT;
              wait_n_reg <= 1'b0;
            end else begin
              state_reg <= S_ACT;
              sn_wr_reg <= sn_hit;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_reg  <= S_IDLE;
            wait_n_reg <= 1'b1;
            wcnt_reg   <= 4'd0;
          end else if (wcnt_reg == 4'd1) begin
            state_reg  <= S_ACT;
            wait_n_reg <= 1'b1;
            wcnt_reg   <= 4'd0;
            sn_wr_reg  <= sn_hit;
          end else begin
            wcnt_reg <= wcnt_reg - 4'd1;
          end
        end
        S_ACT: begin
          state_reg <= S_HOLD;
          if (io_acc && cpu_wr && port == 8'd0)
            ctrl_reg <= cpu_dout;
          if (unmapped) begin
            unmap_addr_reg <= cpu_ab;
            if (unmap_cnt_reg != 8'hFF)
              unmap_cnt_reg <= unmap_cnt_reg + 8'd1;
          end
        end
        S_HOLD: begin
          if (!req)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign sn_wr      = sn_wr_reg;
  assign ctrl_q     = ctrl_reg;
  assign flip       = ctrl_reg[1];
  assign cpu_wait_n = wait_n_reg;
  assign unmap_cnt  = unmap_cnt_reg;
  assign unmap_addr = unmap_addr_reg;

endmodule

// File: tb/tb_jg_bus_ctrl.sv
// Directed bench for jg_bus_ctrl: each access is driven for a fixed number of
// cycles while wait-low cycles, strobe pulses and selects are tallied.
module tb_jg_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_ab;
  logic        cpu_io, cpu_m1, cpu_rd, cpu_wr;
  logic [7:0]  cpu_dout;
  logic        rom_cs, ram1_cs, ram2_cs, vram_cs, cram_cs;
  logic        p1_cs, p2_cs, dsw_cs;
  logic [1:0]  sn_wr;
  logic [7:0]  ctrl_q;
  logic        flip, cpu_wait_n;
  logic [7:0]  unmap_cnt;
  logic [15:0] unmap_addr;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Tallies from the most recent access
  int wait_low, sn0_pulses, sn1_pulses, rom_seen, ram1_seen, ram2_seen;
  int vram_seen, cram_seen, p1_seen, p2_seen, dsw_seen;

  always #5 clk = ~clk;

  jg_bus_ctrl #(
    .NUM_SN(2), .ROM_WAIT(3), .RAM_WAIT(0), .VID_WAIT(1), .IO_WAIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_ab(cpu_ab), .cpu_io(cpu_io), .cpu_m1(cpu_m1),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .rom_cs(rom_cs), .ram1_cs(ram1_cs), .ram2_cs(ram2_cs), .vram_cs(vram_cs),
    .cram_cs(cram_cs), .p1_cs(p1_cs), .p2_cs(p2_cs), .dsw_cs(dsw_cs),
    .sn_wr(sn_wr), .ctrl_q(ctrl_q), .flip(flip), .cpu_wait_n(cpu_wait_n),
    .unmap_cnt(unmap_cnt), .unmap_addr(unmap_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_io = 1'b0; cpu_m1 = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_ab = 16'h0000; cpu_dout = 8'h00;
  endtask

  // Drive one access for n clocks, tally outputs at each falling edge, then release.
  task automatic access(input logic io, input logic m1, input logic rd, input logic wr,
                        input logic [15:0] ab, input logic [7:0] dout, input int n);
    wait_low = 0; sn0_pulses = 0; sn1_pulses = 0; rom_seen = 0; ram1_seen = 0;
    ram2_seen = 0; vram_seen = 0; cram_seen = 0; p1_seen = 0; p2_seen = 0; dsw_seen = 0;
    @(posedge clk); #1;
    cpu_io = io; cpu_m1 = m1; cpu_rd = rd; cpu_wr = wr; cpu_ab = ab; cpu_dout = dout;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!cpu_wait_n) wait_low++;
      if (sn_wr[0]) sn0_pulses++;
      if (sn_wr[1]) sn1_pulses++;
      if (rom_cs) rom_seen++;
      if (ram1_cs) ram1_seen++;
      if (ram2_cs) ram2_seen++;
      if (vram_cs) vram_seen++;
      if (cram_cs) cram_seen++;
      if (p1_cs) p1_seen++;
      if (p2_cs) p2_seen++;
      if (dsw_cs) dsw_seen++;
    end
    @(posedge clk); #1;
    bus_idle();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_n", 32'(cpu_wait_n), 32'h1);
    chk("rst_ctrl_q", 32'(ctrl_q), 32'h0);
    chk("rst_flip", 32'(flip), 32'h0);
    chk("rst_sn_wr", 32'(sn_wr), 32'h0);
    chk("rst_unmap_cnt", 32'(unmap_cnt), 32'h0);
    chk("rst_unmap_addr", 32'(unmap_addr), 32'h0);
    $display("reset: wait_n=%0b ctrl_q=%02h unmap_cnt=%0d", cpu_wait_n, ctrl_q, unmap_cnt);

    // I/O write port 0, data 0x02
    access(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h02, 6);
    chk("ctrl_wait_low", 32'(wait_low), 32'd1);
    chk("ctrl_q", 32'(ctrl_q), 32'h02);
    chk("ctrl_flip", 32'(flip), 32'h1);
    chk("ctrl_no_sn", 32'(sn0_pulses + sn1_pulses), 32'd0);
    $display("io wr p0 <= 02: wait_low=%0d ctrl_q=%02h flip=%0b", wait_low, ctrl_q, flip);

    // I/O write port 2, strobe held 6 cycles
    access(1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 8'h5A, 6);
    chk("sn1_pulses", 32'(sn1_pulses), 32'd1);
    chk("sn0_pulses", 32'(sn0_pulses), 32'd0);
    chk("sn_ctrl_kept", 32'(ctrl_q), 32'h02);
    $display("io wr p2: sn1=%0d sn0=%0d", sn1_pulses, sn0_pulses);

    // I/O write port 1 with zero-gap held strobe
    access(1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 8'hA5, 8);
    chk("sn0_p1_pulses", 32'(sn0_pulses), 32'd1);
    chk("sn1_p1_pulses", 32'(sn1_pulses), 32'd0);
    $display("io wr p1: sn0=%0d sn1=%0d", sn0_pulses, sn1_pulses);

    // ROM read 0x1234, three wait states
    access(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 8);
    chk("rom_cs_held", 32'(rom_seen), 32'd8);
    chk("rom_wait_low", 32'(wait_low), 32'd3);
    chk("rom_no_sn", 32'(sn0_pulses + sn1_pulses), 32'd0);
    $display("rom rd 1234: rom_cs=%0d/8 wait_low=%0d", rom_seen, wait_low);

    // RAM1 zero-wait, RAM2, VRAM and CRAM selects
    access(1'b0, 1'b0, 1'b1, 1'b0, 16'h8010, 8'h00, 4);
    chk("ram1_cs", 32'(ram1_seen), 32'd4);
    chk("ram1_wait_low", 32'(wait_low), 32'd0);
    $display("ram1 rd 8010: ram1_cs=%0d wait_low=%0d", ram1_seen, wait_low);
    access(1'b0, 1'b0, 1'b0, 1'b1, 16'hA7FF, 8'h11, 4);
    chk("ram2_cs", 32'(ram2_seen), 32'd4);
    $display("ram2 wr a7ff: ram2_cs=%0d", ram2_seen);
    access(1'b0, 1'b0, 1'b0, 1'b1, 16'hE3FF, 8'h22, 4);
    chk("vram_cs", 32'(vram_seen), 32'd4);
    chk("vram_not_cram", 32'(cram_seen), 32'd0);
    chk("vram_wait_low", 32'(wait_low), 32'd1);
    $display("vram wr e3ff: vram_cs=%0d cram_cs=%0d wait_low=%0d", vram_seen, cram_seen, wait_low);
    access(1'b0, 1'b0, 1'b1, 1'b0, 16'hE400, 8'h00, 4);
    chk("cram_cs", 32'(cram_seen), 32'd4);
    chk("cram_not_vram", 32'(vram_seen), 32'd0);
    $display("cram rd e400: cram_cs=%0d", cram_seen);

    // I/O read selects
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 4);
    chk("p2_cs", 32'(p2_seen), 32'd4);
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 8'h00, 4);
    chk("p1_cs", 32'(p1_seen), 32'd4);
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 8'h00, 4);
    chk("dsw_cs", 32'(dsw_seen), 32'd4);
    chk("dsw_only", 32'(p1_seen + p2_seen), 32'd0);
    $display("io rd: p2/p1/dsw selects checked");

    // Port 3 write is mapped: no count, no strobe
    access(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 8'hFF, 5);
    chk("p3_no_count", 32'(unmap_cnt), 32'd0);
    chk("p3_no_sn", 32'(sn0_pulses + sn1_pulses), 32'd0);
    chk("p3_ctrl_kept", 32'(ctrl_q), 32'h02);
    $display("io wr p3: unmap_cnt=%0d", unmap_cnt);

    // Unmapped accesses
    access(1'b0, 1'b0, 1'b1, 1'b0, 16'h9000, 8'h00, 4);
    chk("unmap1_cnt", 32'(unmap_cnt), 32'd1);
    chk("unmap1_addr", 32'(unmap_addr), 32'h9000);
    chk("unmap1_no_wait", 32'(wait_low), 32'd0);
    access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 8'h00, 4);
    chk("unmap2_cnt", 32'(unmap_cnt), 32'd2);
    chk("unmap2_addr", 32'(unmap_addr), 32'h0007);
    $display("unmapped 9000, io 07: cnt=%0d addr=%04h", unmap_cnt, unmap_addr);

    // Interrupt acknowledge
    access(1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 8'h00, 5);
    chk("iack_no_sel", 32'(p1_seen + p2_seen + dsw_seen + rom_seen), 32'd0);
    chk("iack_no_wait", 32'(wait_low), 32'd0);
    chk("iack_cnt", 32'(unmap_cnt), 32'd2);
    $display("int ack: sel=%0d wait_low=%0d cnt=%0d", p1_seen + p2_seen + dsw_seen, wait_low, unmap_cnt);

    // Saturation: 300 more unmapped reads
    for (int k = 0; k < 300; k++)
      access(1'b0, 1'b0, 1'b1, 1'b0, 16'hF000 + 16'(k), 8'h00, 3);
    chk("unmap_sat_cnt", 32'(unmap_cnt), 32'd255);
    chk("unmap_last_addr", 32'(unmap_addr), 32'hF12B);
    $display("300 unmapped reads: cnt=%0d addr=%04h", unmap_cnt, unmap_addr);

    // Reset during WAIT of a port 1 write
    wait_low = 0; sn0_pulses = 0;
    @(posedge clk); #1;
    cpu_io = 1'b1; cpu_wr = 1'b1; cpu_ab = 16'h0001; cpu_dout = 8'h33;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wait", 32'(cpu_wait_n), 32'h0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sn_wr[0]) sn0_pulses++;
    end
    chk("abort_wait_n", 32'(cpu_wait_n), 32'h1);
    chk("abort_cnt_cleared", 32'(unmap_cnt), 32'd0);
    bus_idle();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    if (sn_wr[0]) sn0_pulses++;
    chk("abort_no_pulse", 32'(sn0_pulses), 32'd0);
    chk("abort_ctrl_reset", 32'(ctrl_q), 32'h0);
    $display("reset in WAIT: sn0=%0d wait_n=%0b", sn0_pulses, cpu_wait_n);

    // FSM back in IDLE: a fresh port 1 write behaves normally
    access(1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 8'h44, 6);
    chk("post_rst_wait_low", 32'(wait_low), 32'd1);
    chk("post_rst_sn0", 32'(sn0_pulses), 32'd1);
    $display("post-reset io wr p1: wait_low=%0d sn0=%0d", wait_low, sn0_pulses);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
